// File: rtl/time_ctrl_pkg.sv
// Shared types and constants for the time_ctrl timekeeping controller.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_AL  = 2'd3
  } state_e;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/time_ctrl_tick_gen.sv
// 1 Hz time base: divider counting 0..CLK_HZ-1 with full- and half-period strobes.
// clr_i restarts the second so the next tick lands exactly CLK_HZ cycles later.
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o,
  output logic half_tick_o
);

  localparam int DIV_W = $clog2(CLK_HZ);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2 - 1);

  logic [DIV_W-1:0] div_q, div_d;

  // next divider value: clear wins, otherwise compare-and-wrap increment
  always_comb begin
    div_d = div_q + 1'b1;
    if (clr_i || div_q == DIV_MAX) div_d = '0;
  end

  // divider register
  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

  assign tick_o      = (div_q == DIV_MAX);
  assign half_tick_o = (div_q == DIV_HALF);

endmodule

// File: rtl/time_ctrl.sv
// Timekeeping controller: HH:MM:SS counters, set-mode FSM and blink strobe.
// Optional alarm (state SET_AL and alarm output) enabled by TIME_CTRL_ALARM_EN.
//
// state   | meaning
// RUN     | time advances once per tick, btn_inc ignored
// SET_HR  | btn_inc bumps hours (no carry), time frozen, blink active
// SET_MIN | btn_inc bumps minutes (no carry), time frozen, blink active
// SET_AL  | btn_inc bumps alarm time by one minute (alarm build only)
module time_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       mode,
  output logic             blink,
  output logic             tick_1hz
`ifdef TIME_CTRL_ALARM_EN
  ,
  output logic             alarm
`endif
);

  state_e           state_q, state_d;
  logic [HR_W-1:0]  hours_q, hours_d;
  logic [MIN_W-1:0] minutes_q, minutes_d;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic             blink_q, blink_d;
  logic             tick_1hz_q, tick_1hz_d;
  logic             div_clr;
  logic             tick, half_tick;

`ifdef TIME_CTRL_ALARM_EN
  logic [HR_W-1:0]  al_hr_q, al_hr_d;
  logic [MIN_W-1:0] al_min_q, al_min_d;
  logic             alarm_q, alarm_d;
`endif

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk_i       (clkin),
    .rst_i       (rst),
    .clr_i       (div_clr),
    .tick_o      (tick),
    .half_tick_o (half_tick)
  );

  // next-state, field updates and blink; mode change always beats btn_inc
  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    blink_d    = blink_q;
    tick_1hz_d = 1'b0;
    div_clr    = 1'b0;
`ifdef TIME_CTRL_ALARM_EN
    al_hr_d    = al_hr_q;
    al_min_d   = al_min_q;
`endif
    case (state_q)
      RUN: begin
        blink_d    = 1'b0;
        tick_1hz_d = tick;
        if (tick) begin
          if (seconds_q == SEC_MAX) begin
            seconds_d = '0;
            if (minutes_q == MIN_MAX) begin
              minutes_d = '0;
              hours_d   = (hours_q == HR_MAX) ? '0 : hours_q + 1'b1;
            end else begin
              minutes_d = minutes_q + 1'b1;
            end
          end else begin
            seconds_d = seconds_q + 1'b1;
          end
        end
        if (btn_mode) begin
          state_d = SET_HR;
          blink_d = 1'b1;
        end
      end
      SET_HR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
          blink_d = 1'b1;
        end else begin
          if (btn_inc) hours_d = (hours_q == HR_MAX) ? '0 : hours_q + 1'b1;
          if (tick || half_tick) blink_d = ~blink_q;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
`ifdef TIME_CTRL_ALARM_EN
          state_d   = SET_AL;
          blink_d   = 1'b1;
`else
          state_d   = RUN;
          blink_d   = 1'b0;
          seconds_d = '0;
          div_clr   = 1'b1;
`endif
        end else begin
          if (btn_inc) minutes_d = (minutes_q == MIN_MAX) ? '0 : minutes_q + 1'b1;
          if (tick || half_tick) blink_d = ~blink_q;
        end
      end
`ifdef TIME_CTRL_ALARM_EN
      SET_AL: begin
        if (btn_mode) begin
          state_d   = RUN;
          blink_d   = 1'b0;
          seconds_d = '0;
          div_clr   = 1'b1;
        end else begin
          if (btn_inc) begin
            if (al_min_q == MIN_MAX) begin
              al_min_d = '0;
              al_hr_d  = (al_hr_q == HR_MAX) ? '0 : al_hr_q + 1'b1;
            end else begin
              al_min_d = al_min_q + 1'b1;
            end
          end
          if (tick || half_tick) blink_d = ~blink_q;
        end
      end
`endif
      default: begin
        state_d = RUN;
        blink_d = 1'b0;
      end
    endcase
`ifdef TIME_CTRL_ALARM_EN
    // level alarm on the values about to be registered; leaving RUN silences it
    alarm_d = (state_d == RUN) && (hours_d == al_hr_d) && (minutes_d == al_min_d)
              && ((al_hr_d != '0) || (al_min_d != '0));
`endif
  end

  // state and field registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= RUN;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      blink_q    <= 1'b0;
      tick_1hz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      blink_q    <= blink_d;
      tick_1hz_q <= tick_1hz_d;
    end
  end

`ifdef TIME_CTRL_ALARM_EN
  // alarm time and alarm flag registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      al_hr_q  <= '0;
      al_min_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      alarm_q  <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign mode     = state_q;
  assign blink    = blink_q;
  assign tick_1hz = tick_1hz_q;

endmodule

// File: tb/tb_time_ctrl.sv
// Bench for time_ctrl with CLK_HZ=4: vector table, directed corner cases and
// randomized buttons checked every cycle against a seconds-of-day model.
module tb_time_ctrl;

  localparam int HZ = 4;

  logic       clkin = 1'b0;
  logic       rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] mode;
  logic       blink, tick_1hz;
`ifdef TIME_CTRL_ALARM_EN
  logic       alarm;
`endif

  time_ctrl #(.CLK_HZ(HZ)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .blink    (blink),
    .tick_1hz (tick_1hz)
`ifdef TIME_CTRL_ALARM_EN
    ,
    .alarm    (alarm)
`endif
  );

  always #5 clkin = ~clkin;

  int total = 0;
  int bad   = 0;

  // model: time as seconds since midnight, alarm as minutes since midnight
  int m_t, m_mode, m_phase, m_blink, m_tick, m_al, m_alarm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_exit_to_run();
    m_mode  = 0;
    m_t     = m_t - (m_t % 60);
    m_phase = 0;
    m_blink = 0;
  endtask

  task automatic model_step(input bit r, input bit bm, input bit bi);
    bit tk, hf;
    int mm;
    if (r) begin
      m_t = 0; m_mode = 0; m_phase = 0; m_blink = 0; m_tick = 0; m_al = 0; m_alarm = 0;
      return;
    end
    tk      = (m_phase == HZ - 1);
    hf      = (m_phase == HZ / 2 - 1);
    m_phase = (m_phase + 1) % HZ;
    m_tick  = (tk && m_mode == 0) ? 1 : 0;
    case (m_mode)
      0: begin
        if (tk) m_t = (m_t + 1) % 86400;
        m_blink = 0;
        if (bm) begin m_mode = 1; m_blink = 1; end
      end
      1: begin
        if (bm) begin m_mode = 2; m_blink = 1; end
        else begin
          if (bi) m_t = (m_t + 3600) % 86400;
          if (tk || hf) m_blink ^= 1;
        end
      end
      2: begin
        if (bm) begin
`ifdef TIME_CTRL_ALARM_EN
          m_mode = 3; m_blink = 1;
`else
          model_exit_to_run();
`endif
        end else begin
          if (bi) begin
            mm  = (m_t / 60) % 60;
            m_t = m_t - mm * 60 + ((mm + 1) % 60) * 60;
          end
          if (tk || hf) m_blink ^= 1;
        end
      end
      default: begin
        if (bm) model_exit_to_run();
        else begin
          if (bi) m_al = (m_al + 1) % 1440;
          if (tk || hf) m_blink ^= 1;
        end
      end
    endcase
    m_alarm = (m_mode == 0 && m_al != 0 && (m_t / 60) == m_al) ? 1 : 0;
  endtask

  // one clock: drive inputs, let the DUT sample, step the model, compare
  task automatic cycle(input bit r, input bit bm, input bit bi);
    logic [31:0] act, exp;
    rst = r; btn_mode = bm; btn_inc = bi;
    @(posedge clkin);
    model_step(r, bm, bi);
    #1;
    act = 32'({hours, minutes, seconds, mode, blink, tick_1hz});
    exp = ((m_t / 3600) << 16) | (((m_t / 60) % 60) << 10) | ((m_t % 60) << 4)
          | (m_mode << 2) | (m_blink << 1) | m_tick;
    chk("model_state", act, exp);
`ifdef TIME_CTRL_ALARM_EN
    chk("model_alarm", 32'(alarm), 32'(m_alarm));
`endif
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic leave_set();
`ifdef TIME_CTRL_ALARM_EN
    cycle(0, 1, 0);
`endif
    cycle(0, 1, 0);
  endtask

  task automatic chk_time(input string nm, input int hh, input int mm, input int ss, input int md);
    chk({nm, "_hh"}, 32'(hours), 32'(hh));
    chk({nm, "_mm"}, 32'(minutes), 32'(mm));
    chk({nm, "_ss"}, 32'(seconds), 32'(ss));
    chk({nm, "_mode"}, 32'(mode), 32'(md));
  endtask

  typedef struct {
    bit bm;
    bit bi;
    int hh;
    int mm;
    int ss;
    int md;
  } vec_t;

  vec_t tbl[7];
  int   ticks;

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 1, 0, 0, 1};
    tbl[2] = '{0, 1, 2, 0, 0, 1};
    tbl[3] = '{0, 1, 3, 0, 0, 1};
    tbl[4] = '{1, 0, 3, 0, 0, 2};
    tbl[5] = '{0, 1, 3, 1, 0, 2};
    tbl[6] = '{0, 1, 3, 2, 0, 2};

    // reset values
    cycle(1, 0, 0);
    chk_time("reset", 0, 0, 0, 0);
    chk("reset_blink", 32'(blink), 0);
    chk("reset_tick", 32'(tick_1hz), 0);

    // set sequence from the vector table
    for (int i = 0; i < 7; i++) begin
      cycle(0, tbl[i].bm, tbl[i].bi);
      chk_time($sformatf("tbl%0d", i), tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].md);
    end
    leave_set();
    chk_time("set_exit", 3, 2, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0);
      chk("first_tick_early", 32'(tick_1hz), 0);
    end
    cycle(0, 0, 0);
    chk("first_tick_on_time", 32'(tick_1hz), 1);
    chk("first_tick_sec", 32'(seconds), 1);

    // rollover: set 23:59, run to 23:59:58 then through midnight
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 23; i++) cycle(0, 0, 1);
    cycle(0, 1, 0);
    for (int i = 0; i < 59; i++) cycle(0, 0, 1);
    leave_set();
    for (int i = 0; i < 58 * HZ; i++) cycle(0, 0, 0);
    chk_time("roll_pre", 23, 59, 58, 0);
    ticks = 0;
    for (int i = 0; i < HZ; i++) begin cycle(0, 0, 0); ticks += int'(tick_1hz); end
    chk_time("roll_59", 23, 59, 59, 0);
    for (int i = 0; i < HZ; i++) begin cycle(0, 0, 0); ticks += int'(tick_1hz); end
    chk_time("roll_mid", 0, 0, 0, 0);
    chk("roll_tick_count", 32'(ticks), 2);

    // hour wrap in SET_HR, blink forced on entry
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    chk("blink_entry", 32'(blink), 1);
    for (int i = 0; i < 24; i++) cycle(0, 0, 1);
    chk_time("hr_wrap", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);

    // collision: mode change wins over increment
    cycle(0, 1, 1);
    chk_time("collide", 5, 0, 0, 2);

    // reset mid-set at 05:07
    for (int i = 0; i < 7; i++) cycle(0, 0, 1);
    chk_time("pre_rst", 5, 7, 0, 2);
    cycle(1, 0, 0);
    chk_time("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_blink", 32'(blink), 0);

`ifdef TIME_CTRL_ALARM_EN
    // alarm at 00:01 rises with minute 1, btn_mode clears it
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("al_mode", 32'(mode), 3);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    for (int i = 0; i < 60 * HZ - 1; i++) cycle(0, 0, 0);
    chk("alarm_early", 32'(alarm), 0);
    cycle(0, 0, 0);
    chk("alarm_rise", 32'(alarm), 1);
    chk("alarm_min", 32'(minutes), 1);
    cycle(0, 1, 0);
    chk("alarm_clear", 32'(alarm), 0);
`endif

    // randomized buttons and occasional reset against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
